spi_target: RTL

- SPI mode-0 responder (target) for the opposite end of the Processor's SPI master link (spi_cs/spi_sck/spi_mosi/spi_miso).
- Oversamples the asynchronous SPI pins on the system clock.
- Deframes MOSI into bytes and serialises a byte stream onto MISO, with a valid/ready handshake on the core side.
- Used as a board-level peripheral model and as a loopback/companion target in the same TinyTapeout design.

---
 rtl/spi_target.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_target.sv
// ============================================================================
//  Module      : spi_target
//  Description : SPI mode-0 target. Oversamples the SPI pins on clk, deframes
//                MOSI into bytes and serialises a one-deep transmit buffer onto
//                MISO. Build option SPI_TARGET_LSB_FIRST_EN selects LSB-first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       busy
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    // Pin synchronisers; cs presets high and sck low so reset release is edge-free
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_sck_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_sck_d     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    logic w_cs_s;
    logic w_sck_s;
    logic w_mosi_s;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_d & ~w_cs_s;
    assign w_cs_rise  = ~r_cs_d & w_cs_s;
    assign w_sck_rise = ~r_sck_d & w_sck_s;
    assign w_sck_fall = r_sck_d & ~w_sck_s;

    logic [0:0] r_state;
    logic [2:0] r_bit_cnt;
    logic       r_load_pending;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_underrun;
    logic [7:0] r_buf;
    logic       r_buf_full;

    logic       w_in_shift;
    logic       w_start;
    logic       w_stop;
    logic       w_rx_edge;
    logic       w_tx_edge;
    logic       w_reload;
    logic       w_accept;
    logic [7:0] w_reload_byte;
    logic [7:0] w_rx_next;
    logic [7:0] w_tx_shifted;
    logic       w_miso_bit;

    // A cs rise outranks any sck edge detected in the same cycle
    assign w_in_shift    = (r_state == c_ST_SHIFT);
    assign w_start       = (r_state == c_ST_IDLE) & w_cs_fall;
    assign w_stop        = w_in_shift & w_cs_rise;
    assign w_rx_edge     = w_in_shift & ~w_cs_rise & w_sck_rise;
    assign w_tx_edge     = w_in_shift & ~w_cs_rise & w_sck_fall;
    assign w_reload      = w_start | (w_tx_edge & r_load_pending);
    assign w_accept      = tx_valid & ~r_buf_full;
    assign w_reload_byte = r_buf_full ? r_buf : IDLE_BYTE;

`ifdef SPI_TARGET_LSB_FIRST_EN
    assign w_rx_next    = {w_mosi_s, r_rx_shift[7:1]};
    assign w_tx_shifted = {1'b0, r_tx_shift[7:1]};
    assign w_miso_bit   = r_tx_shift[0];
`else
    assign w_rx_next    = {r_rx_shift[6:0], w_mosi_s};
    assign w_tx_shifted = {r_tx_shift[6:0], 1'b0};
    assign w_miso_bit   = r_tx_shift[7];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_bit_cnt      <= 3'd0;
            r_load_pending <= 1'b0;
            r_rx_shift     <= 8'h00;
            r_tx_shift     <= 8'h00;
            r_rx_data      <= 8'h00;
            r_rx_valid     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_start) begin
                r_state        <= c_ST_SHIFT;
                r_bit_cnt      <= 3'd0;
                r_load_pending <= 1'b0;
                r_tx_shift     <= w_reload_byte;
            end else if (w_stop) begin
                r_state        <= c_ST_IDLE;
                r_bit_cnt      <= 3'd0;
                r_load_pending <= 1'b0;
                r_rx_shift     <= 8'h00;
                r_tx_shift     <= 8'h00;
            end else begin
                if (w_rx_edge) begin
                    r_rx_shift <= w_rx_next;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_rx_data      <= w_rx_next;
                        r_rx_valid     <= 1'b1;
                        r_load_pending <= 1'b1;
                    end
                end
                if (w_tx_edge) begin
                    if (r_load_pending) begin
                        r_tx_shift     <= w_reload_byte;
                        r_load_pending <= 1'b0;
                    end else begin
                        r_tx_shift <= w_tx_shifted;
                    end
                end
            end
        end
    end

    // Accept can only happen while empty, so a same-cycle reload has already
    // taken IDLE_BYTE and the new byte simply fills the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf         <= 8'h00;
            r_buf_full    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= w_reload & ~r_buf_full;
            if (w_accept) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_reload) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    assign spi_miso    = w_in_shift & w_miso_bit;
    assign spi_miso_oe = w_in_shift;
    assign busy        = w_in_shift;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = ~r_buf_full;
    assign tx_underrun = r_tx_underrun;

endmodule

`default_nettype wire
